// File: rtl/lcd_image_fetch.sv
// Raster pixel source: walks the active frame, fetches the windowed image from a
// 1-cycle-latency ROM and presents it as a valid/ready stream through a 2-deep FIFO.
module lcd_image_fetch #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 16,
    parameter int H_ACTIVE = 480,
    parameter int V_ACTIVE = 272,
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter logic [DATA_WIDTH-1:0] BG_COLOR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [9:0]            img_x,
    input  logic [9:0]            img_y,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  busy
);

    localparam int EW = DATA_WIDTH + 2;
    localparam logic [10:0] H11 = 11'(H_ACTIVE);
    localparam logic [10:0] V11 = 11'(V_ACTIVE);
    localparam logic [10:0] W11 = 11'(IMG_W);
    localparam logic [10:0] IH11 = 11'(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state;
    logic [9:0]              x, y, win_x, win_y;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic                    inflight, s_win, s_sof, s_eol;
    logic [1:0]              fifo_count;
    logic [EW-1:0]           fifo_q0, fifo_q1;

    logic [10:0]             x11, y11, left, right, top, bottom, clip;
    logic                    row_in, in_win, last_col, last_row, pop, issue;
    logic [ADDR_WIDTH-1:0]   addr_step;
    logic [EW-1:0]           push_entry;

    assign x11      = {1'b0, x};
    assign y11      = {1'b0, y};
    assign left     = {1'b0, win_x};
    assign top      = {1'b0, win_y};
    assign right    = left + W11;
    assign bottom   = top + IH11;
    assign row_in   = (y11 >= top) && (y11 < bottom);
    assign in_win   = row_in && (x11 >= left) && (x11 < right);
    assign last_col = (x11 == H11 - 11'd1);
    assign last_row = (y11 == V11 - 11'd1);

    assign pop   = pix_valid & pix_ready;
    // Credit counts this cycle's pop so a full pipeline still issues every clock.
    assign issue = (state == RUN) &&
                   (({1'b0, fifo_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

    // Columns of the window that fall past the right edge still consume ROM addresses.
    always_comb begin
        clip = '0;
        if (right > H11)
            clip = (left >= H11) ? W11 : (right - H11);
    end

    always_comb begin
        addr_step = ADDR_WIDTH'(in_win);
        if (last_col && row_in && !last_row)
            addr_step = addr_step + ADDR_WIDTH'(clip);
    end

    assign rom_addr   = addr_cnt;
    assign push_entry = {s_win ? rom_data : BG_COLOR, s_sof, s_eol};
    assign pix_valid  = (fifo_count != 2'd0);
    assign {pix_data, pix_sof, pix_eol} = fifo_q0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            x          <= '0;
            y          <= '0;
            win_x      <= '0;
            win_y      <= '0;
            addr_cnt   <= '0;
            inflight   <= 1'b0;
            s_win      <= 1'b0;
            s_sof      <= 1'b0;
            s_eol      <= 1'b0;
            fifo_count <= '0;
            fifo_q0    <= '0;
            fifo_q1    <= '0;
        end else if (frame_start) begin
            state      <= RUN;
            busy       <= 1'b1;
            win_x      <= img_x;
            win_y      <= img_y;
            x          <= '0;
            y          <= '0;
            addr_cnt   <= '0;
            inflight   <= 1'b0;
            fifo_count <= '0;
        end else begin
            inflight <= issue;
            s_win    <= in_win;
            s_sof    <= (x == '0) && (y == '0);
            s_eol    <= last_col;

            if (issue) begin
                addr_cnt <= addr_cnt + addr_step;
                if (last_col) begin
                    x <= '0;
                    if (last_row)
                        state <= DRAIN;
                    else
                        y <= y + 10'd1;
                end else begin
                    x <= x + 10'd1;
                end
            end

            if (state == DRAIN && fifo_count == 2'd0 && !inflight) begin
                state <= IDLE;
                busy  <= 1'b0;
            end

            case ({inflight, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) fifo_q0 <= push_entry;
                    else                    fifo_q1 <= push_entry;
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    fifo_q0    <= fifo_q1;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        fifo_q0 <= push_entry;
                    end else begin
                        fifo_q0 <= fifo_q1;
                        fifo_q1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_image_fetch.sv
// Directed bench for lcd_image_fetch on a small 8x4 frame with a 4x2 image window;
// expected pixels are queued at each frame_start and popped on every accepted pixel.
module tb_lcd_image_fetch;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int IW = 4;
    localparam int IH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_ready = 1'b0;
    logic [9:0]  img_x = '0;
    logic [9:0]  img_y = '0;
    logic [16:0] rom_addr;
    logic [15:0] rom_data = '0;
    logic [15:0] pix_data;
    logic        pix_valid, pix_sof, pix_eol, busy;

    int n_checks = 0;
    int n_fail = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= 16'h0100 + rom_addr[15:0];

    lcd_image_fetch #(
        .ADDR_WIDTH(17), .DATA_WIDTH(16), .H_ACTIVE(H), .V_ACTIVE(V),
        .IMG_W(IW), .IMG_H(IH), .BG_COLOR(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .img_x(img_x), .img_y(img_y),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, pix_valid, 0);
        check({tag, "_data"}, pix_data, 0);
        check({tag, "_sof"}, pix_sof, 0);
        check({tag, "_eol"}, pix_eol, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_addr"}, rom_addr, 0);
    endtask

    // Pulse frame_start for one cycle and queue the full expected frame.
    task automatic start_frame(input int ix, input int iy);
        @(negedge clk);
        pix_ready   = 1'b0;
        img_x       = 10'(ix);
        img_y       = 10'(iy);
        frame_start = 1'b1;
        exp_q.delete();
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                logic        inw;
                logic [15:0] d;
                inw = (xx >= ix) && (xx < ix + IW) && (yy >= iy) && (yy < iy + IH);
                d = inw ? 16'(32'h0100 + (yy - iy) * IW + (xx - ix)) : 16'h0000;
                exp_q.push_back({d, 1'(xx == 0 && yy == 0), 1'(xx == H - 1)});
            end
        end
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // mode 0: ready high; 1: random ready; 2: 20-cycle stall once pixel 12 is at the head.
    task automatic run_frame(input int mode, input int stop_after,
                             output int first_valid, output int last_acc,
                             output logic [16:0] max_addr);
        int          cyc = 1;
        int          acc = 0;
        int          stall_left = 0;
        logic        stalled_once = 1'b0;
        logic        prev_stall = 1'b0;
        logic [17:0] prev_out = '0;
        logic [17:0] obs;
        first_valid = -1;
        last_acc    = -1;
        max_addr    = '0;
        while (acc < stop_after) begin
            if (cyc > 500) begin
                check("timeout_accepts", acc, stop_after);
                break;
            end
            obs = {pix_data, pix_sof, pix_eol};
            if (cyc == 1) check("busy_after_start", busy, 1);
            if (pix_valid && first_valid < 0) first_valid = cyc;
            if (rom_addr > max_addr) max_addr = rom_addr;
            if (prev_stall) begin
                check("stall_valid", pix_valid, 1);
                check("stall_hold", obs, prev_out);
            end
            if (mode == 1) check("fifo_count_le2", dut.fifo_count <= 2'd2, 1);
            case (mode)
                0: pix_ready = 1'b1;
                1: pix_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (acc == 12 && !stalled_once) begin
                        stall_left   = 20;
                        stalled_once = 1'b1;
                    end
                    pix_ready = (stall_left == 0);
                    if (stall_left > 0) begin
                        stall_left--;
                        if (stall_left == 0) begin
                            check("stall_fifo_full", dut.fifo_count, 2);
                            check("stall_no_inflight", dut.inflight, 0);
                            check("stall_head", obs, exp_q[0]);
                        end
                    end
                end
            endcase
            if (pix_valid && pix_ready) begin
                acc++;
                last_acc = cyc;
                check("queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("pixel", obs, exp_q.pop_front());
            end
            prev_stall = pix_valid && !pix_ready;
            prev_out   = obs;
            if (acc < stop_after) begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic finish_frame(output int k);
        k = 0;
        while (busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("busy_drop", busy, 0);
        check("idle_valid", pix_valid, 0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int          fv, la, k;
        logic [16:0] ma;

        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Full frame, ready held high
        start_frame(2, 1);
        run_frame(0, 32, fv, la, ma);
        check("first_valid_latency", fv, 3);
        check("last_accept_cycle", la, 34);
        finish_frame(k);
        check("busy_drop_cycles", k, 2);

        // Random backpressure
        start_frame(2, 1);
        run_frame(1, 32, fv, la, ma);
        finish_frame(k);

        // Window clipped at the bottom-right corner
        start_frame(6, 3);
        run_frame(0, 32, fv, la, ma);
        check("clip_max_addr", ma <= 17'd3, 1);
        finish_frame(k);

        // Restart after 10 accepted pixels
        start_frame(2, 1);
        run_frame(0, 10, fv, la, ma);
        start_frame(2, 1);
        run_frame(0, 32, fv, la, ma);
        check("restart_latency", fv, 3);
        finish_frame(k);

        // Asynchronous reset mid-frame, then a clean frame
        start_frame(2, 1);
        run_frame(0, 13, fv, la, ma);
        #2 rst = 1'b1;
        #1 check_reset("async_reset");
        @(negedge clk);
        rst = 1'b0;
        start_frame(2, 1);
        run_frame(0, 32, fv, la, ma);
        finish_frame(k);

        // Long stall at pixel 12
        start_frame(2, 1);
        run_frame(2, 32, fv, la, ma);
        finish_frame(k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
